idu_seq: RTL and testbench
==========================

Name: idu_seq

Overview:
Increment/decrement sequencer that sits directly upstream of the register file and drives its control strobes.
- Accepts one 16-bit pair command per handshake and targets one of BC/DE/HL/SP/PC.
- Sequences read (oe) -> compute -> write-back (wr) against the register file's pair/PC/SP ports.
- Returns the final value to the control unit.
- Guarantees a read strobe and a write strobe are never asserted in the same cycle.

Parameters:
W, 16, pair data width
LR_BC, 2'd0, lr_sel encoding for BC
LR_DE, 2'd1, lr_sel encoding for DE
LR_HL, 2'd2, lr_sel encoding for HL

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
req  input  1  command request; sampled only in IDLE
cmd_sel  input  3  target: 0=BC 1=DE 2=HL 3=SP 4=PC, 5-7 invalid
cmd_op  input  2  00=INC 01=DEC 10=LOAD imm 11=READ only
imm  input  W  value written by LOAD
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle pulse in DONE
err  output  1  one-cycle pulse with done for invalid cmd_sel
result  output  W  final pair value; held until next accept
lr_sel  output  2  register-file pair select
l_oe, r_oe  output  1 each  high/low byte output enables to register file
l_wr, r_wr  output  1 each  high/low byte write strobes
pc_oe, pc_wr, sp_oe, sp_wr  output  1 each  PC/SP enables
lr_in  input  W  value read back from selected source (pair, PC or SP)
lr_out  output  W  value driven for write
lr_drive  output  1  enables lr_out onto the shared bus; high only in WRITE

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - busy, done, err, all oe/wr strobes, lr_drive = 0.
  - result=0, lr_out=0, lr_sel=0.
- States: IDLE, READ, CALC, WRITE, DONE.
- IDLE: on rising edge with req=1, latch cmd_sel, cmd_op and imm. Next state:
  - INC/DEC/READ-only -> READ.
  - LOAD -> WRITE.
  - invalid cmd_sel -> DONE with err set.
- READ (1 cycle):
  - Assert the source's oe: l_oe and r_oe for pairs, pc_oe for PC, sp_oe for SP.
  - lr_sel is valid for the whole cycle.
  - lr_in is captured into the work register at the closing edge.
  - Next state: CALC for INC/DEC; DONE for READ-only.
- CALC (1 cycle):
  - INC: work+1. DEC: work-1. Modulo 2^16 with no flags: 0xFFFF+1=0x0000, 0x0000-1=0xFFFF.
  - No strobes asserted.
- WRITE (1 cycle):
  - lr_out = computed value, or latched imm for LOAD; lr_drive=1.
  - Assert the matching wr: l_wr and r_wr for pairs, pc_wr for PC, sp_wr for SP.
  - No oe asserted.
- DONE (1 cycle):
  - done=1; result updated with the final value (the read value for READ-only).
  - err=1 only for invalid commands; result unchanged on err.
  - Returns to IDLE. The next req is accepted in the following IDLE cycle at the earliest; back-to-back throughput is one command per (latency+1) cycles.
- Latency from accept edge to done cycle:
  - INC/DEC: 4 cycles (READ, CALC, WRITE, DONE).
  - LOAD: 2 cycles.
  - READ-only: 2 cycles.
  - invalid: 1 cycle.
- Strobe rules:
  - req while busy is ignored, with no queueing.
  - At most one oe group active per cycle; oe and wr are never asserted together.
  - All strobes are driven from registered state, glitch-free.
- Reset asserted mid-operation: strobes drop immediately (async); a partial write is not completed; result=0.

Optional Feature:
IDU_ADDR_OUT_EN
- Defined:
  - Extra outputs addr_out (W) and addr_valid (1).
  - In the CALC cycle of INC/DEC, addr_out = pre-op work value and addr_valid=1; otherwise addr_valid=0 and addr_out holds its last value.
  - Purpose: post-increment/decrement memory addressing.
  - Reset: addr_out=0, addr_valid=0.
- Undefined: ports are absent; all other behaviour identical.

Test Plan:
- Reset then INC HL with lr_in=0x12FF -> READ l_oe=r_oe=1 lr_sel=2; WRITE lr_out=0x1300 l_wr=r_wr=1; done 4 cycles after accept; result=0x1300.
- DEC SP with lr_in=0x0000 -> sp_oe in READ; sp_wr with lr_out=0xFFFF in WRITE; result=0xFFFF (wrap).
- LOAD PC imm=0x0150 -> no oe at any point; pc_wr with lr_out=0x0150 one cycle after accept; done next cycle.
- cmd_sel=6 -> no strobes; done=err=1 one cycle after accept; result keeps prior value.
- req held high through an INC BC, imm and cmd changed mid-op -> latched values used; second command accepted only in the first IDLE cycle after done.
- rst pulled low during WRITE of INC DE -> all strobes 0 immediately; after release busy=0, result=0; with IDU_ADDR_OUT_EN, INC DE from 0x8000 gives addr_out=0x8000 with addr_valid=1 in CALC.

Source files
------------

// File: rtl/idu_seq.sv
// idu_seq: 16-bit pair increment/decrement/load/read sequencer driving register-file strobes (optional IDU_ADDR_OUT_EN adds addr_out/addr_valid)
module idu_seq #(
  parameter int         W     = 16,
  parameter logic [1:0] LR_BC = 2'd0,
  parameter logic [1:0] LR_DE = 2'd1,
  parameter logic [1:0] LR_HL = 2'd2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic [2:0]   cmd_sel,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] imm,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic [1:0]   lr_sel,
  output logic         l_oe,
  output logic         r_oe,
  output logic         l_wr,
  output logic         r_wr,
  output logic         pc_oe,
  output logic         pc_wr,
  output logic         sp_oe,
  output logic         sp_wr,
  input  logic [W-1:0] lr_in,
  output logic [W-1:0] lr_out,
  output logic         lr_drive
`ifdef IDU_ADDR_OUT_EN
  ,
  output logic [W-1:0] addr_out,
  output logic         addr_valid
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE} state_t;
  localparam logic [1:0]   OP_INC  = 2'd0;
  localparam logic [1:0]   OP_LOAD = 2'd2;
  localparam logic [1:0]   OP_READ = 2'd3;
  localparam logic [W-1:0] ONE     = 1;
  state_t       r_state;
  logic [2:0]   r_sel;
  logic [1:0]   r_op;
  logic [W-1:0] r_work;
  logic [2:0]   w_tgt;
  logic         w_pair;
  logic         w_sp;
  logic         w_pc;
  logic [1:0]   w_lr;
  logic [W-1:0] w_calc;
  // Target decode uses the incoming command while idle so strobes for the first state are registered at accept.
  assign w_tgt  = (r_state == S_IDLE) ? cmd_sel : r_sel;
  assign w_pair = w_tgt < 3'd3;
  assign w_sp   = w_tgt == 3'd3;
  assign w_pc   = w_tgt == 3'd4;
  assign w_lr   = (w_tgt == 3'd0) ? LR_BC : (w_tgt == 3'd1) ? LR_DE : LR_HL;
  assign w_calc = (r_op == OP_INC) ? r_work + ONE : r_work - ONE;
  // Sequencer: every strobe is set on entry to the state that owns it and cleared on exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_op     <= '0;
      r_work   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      lr_sel   <= '0;
      {l_oe, r_oe, pc_oe, sp_oe} <= '0;
      {l_wr, r_wr, pc_wr, sp_wr} <= '0;
      lr_out   <= '0;
      lr_drive <= 1'b0;
`ifdef IDU_ADDR_OUT_EN
      addr_out   <= '0;
      addr_valid <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (req) begin
          r_sel  <= cmd_sel;
          r_op   <= cmd_op;
          r_work <= imm;
          busy   <= 1'b1;
          if (w_pair) lr_sel <= w_lr;
          if (cmd_sel > 3'd4) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            err     <= 1'b1;
          end else if (cmd_op == OP_LOAD) begin
            r_state  <= S_WRITE;
            lr_out   <= imm;
            lr_drive <= 1'b1;
            {l_wr, r_wr, pc_wr, sp_wr} <= {w_pair, w_pair, w_pc, w_sp};
          end else begin
            r_state <= S_READ;
            {l_oe, r_oe, pc_oe, sp_oe} <= {w_pair, w_pair, w_pc, w_sp};
          end
        end
        S_READ: begin
          r_work <= lr_in;
          {l_oe, r_oe, pc_oe, sp_oe} <= '0;
          if (r_op == OP_READ) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            result  <= lr_in;
          end else begin
            r_state <= S_CALC;
`ifdef IDU_ADDR_OUT_EN
            addr_out   <= lr_in;
            addr_valid <= 1'b1;
`endif
          end
        end
        S_CALC: begin
          r_work   <= w_calc;
          r_state  <= S_WRITE;
          lr_out   <= w_calc;
          lr_drive <= 1'b1;
          {l_wr, r_wr, pc_wr, sp_wr} <= {w_pair, w_pair, w_pc, w_sp};
`ifdef IDU_ADDR_OUT_EN
          addr_valid <= 1'b0;
`endif
        end
        S_WRITE: begin
          {l_wr, r_wr, pc_wr, sp_wr} <= '0;
          lr_drive <= 1'b0;
          r_state  <= S_DONE;
          done     <= 1'b1;
          result   <= r_work;
        end
        S_DONE: begin
          done    <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_idu_seq.sv
// tb_idu_seq: randomized self-checking bench for idu_seq against a phase-list reference model
module tb_idu_seq;
  logic        clk = 0;
  logic        rst = 0;
  logic        req = 0;
  logic [2:0]  cmd_sel = 0;
  logic [1:0]  cmd_op = 0;
  logic [15:0] imm = 0;
  logic [15:0] lr_in = 0;
  logic        busy, done, err, l_oe, r_oe, l_wr, r_wr, pc_oe, pc_wr, sp_oe, sp_wr, lr_drive;
  logic [15:0] result, lr_out;
  logic [1:0]  lr_sel;
`ifdef IDU_ADDR_OUT_EN
  logic [15:0] addr_out;
  logic        addr_valid;
`endif
  logic [11:0] strb;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_res = 0;
  logic [1:0]  exp_lr = 0;

  idu_seq dut (
    .clk(clk), .rst(rst), .req(req), .cmd_sel(cmd_sel), .cmd_op(cmd_op), .imm(imm),
    .busy(busy), .done(done), .err(err), .result(result), .lr_sel(lr_sel),
    .l_oe(l_oe), .r_oe(r_oe), .l_wr(l_wr), .r_wr(r_wr),
    .pc_oe(pc_oe), .pc_wr(pc_wr), .sp_oe(sp_oe), .sp_wr(sp_wr),
    .lr_in(lr_in), .lr_out(lr_out), .lr_drive(lr_drive)
`ifdef IDU_ADDR_OUT_EN
    , .addr_out(addr_out), .addr_valid(addr_valid)
`endif
  );

  always #5 clk = ~clk;
  assign strb = {l_oe, r_oe, pc_oe, sp_oe, l_wr, r_wr, pc_wr, sp_wr, lr_drive, done, err, busy};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Phase codes: 0=read, 1=calc, 2=write, 3=done.
  function automatic logic [11:0] exp_strb(input int ph, input int sel);
    logic p, pc, sp;
    p  = sel < 3;
    pc = sel == 4;
    sp = sel == 3;
    case (ph)
      0:       return {p, p, pc, sp, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
      1:       return 12'h001;
      2:       return {4'b0000, p, p, pc, sp, 1'b1, 1'b0, 1'b0, 1'b1};
      default: return {8'h00, 1'b0, 1'b1, sel > 4, 1'b1};
    endcase
  endfunction

  task automatic do_cmd(input int sel, input int op, input logic [15:0] iv, input logic [15:0] v);
    int          ph[$];
    logic [15:0] fin;
    for (int i = 0; i < 10 && busy; i++) step();
    chk("idle_wait", busy, 0);
    if (sel > 4) ph = '{3};
    else if (op < 2) ph = '{0, 1, 2, 3};
    else if (op == 2) ph = '{2, 3};
    else ph = '{0, 3};
    fin = (op == 0) ? v + 16'd1 : (op == 1) ? v - 16'd1 : (op == 2) ? iv : v;
    if (sel < 3) exp_lr = 2'(sel);
    req = 1; cmd_sel = 3'(sel); cmd_op = 2'(op); imm = iv; lr_in = v;
    step();
    foreach (ph[k]) begin
      req = 1'($urandom_range(0, 1));
      cmd_sel = 3'($urandom); cmd_op = 2'($urandom); imm = 16'($urandom);
      lr_in = (ph[k] == 0) ? v : 16'($urandom);
      chk("strobes", strb, exp_strb(ph[k], sel));
      if ((ph[k] == 0 || ph[k] == 2) && sel < 3) chk("lr_sel", lr_sel, exp_lr);
      if (ph[k] == 2) chk("lr_out", lr_out, fin);
      if (ph[k] == 3) begin
        if (sel <= 4) exp_res = fin;
        chk("result", result, exp_res);
      end
`ifdef IDU_ADDR_OUT_EN
      chk("addr_valid", addr_valid, ph[k] == 1);
      if (ph[k] == 1) chk("addr_out", addr_out, v);
`endif
      step();
    end
    req = 0;
    chk("back_idle", strb, 0);
    chk("held_result", result, exp_res);
  endtask

  task automatic rst_mid(input logic [15:0] v);
    for (int i = 0; i < 10 && busy; i++) step();
    req = 1; cmd_sel = 3'd1; cmd_op = 2'd0; lr_in = v;
    step();
    req = 0;
    step();
    step();
    chk("pre_rst_write", strb, exp_strb(2, 1));
    chk("pre_rst_lr_out", lr_out, v + 16'd1);
    rst = 0;
    #1;
    chk("rst_strobes", strb, 0);
    chk("rst_result", result, 0);
    chk("rst_lr_out", lr_out, 0);
    chk("rst_lr_sel", lr_sel, 0);
    #1 rst = 1;
    step();
    exp_res = 0;
    exp_lr = 0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_result", result, 0);
  endtask

  initial begin
    logic [15:0] v;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", strb, 0);
    chk("reset_result", result, 0);
    chk("reset_lr_out", lr_out, 0);
    chk("reset_lr_sel", lr_sel, 0);
`ifdef IDU_ADDR_OUT_EN
    chk("reset_addr", {addr_valid, addr_out}, 0);
`endif
    rst = 1;
    step();
    do_cmd(2, 0, 16'h0000, 16'h12FF);
    do_cmd(3, 1, 16'h0000, 16'h0000);
    do_cmd(4, 2, 16'h0150, 16'h5555);
    do_cmd(6, 0, 16'hAAAA, 16'h1234);
    do_cmd(0, 0, 16'h0000, 16'hFFFF);
    do_cmd(1, 0, 16'h0000, 16'h8000);
    do_cmd(4, 3, 16'h0000, 16'hBEEF);
    rst_mid(16'h00FF);
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'h0000;
        1:       v = 16'hFFFF;
        default: v = 16'($urandom);
      endcase
      do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 16'($urandom), v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
